// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM state encoding, phase counts and default access timing for sram_ctrl_64b
package sram_ctrl_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD = 2'd1;
  localparam logic [1:0] S_WR = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int RD_PHASES = 4;
  localparam int WR_PHASES = 2;
  localparam int DEF_ACCESS_CYCLES = 2;
endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: wait-cycle counter plus halfword index; in clk,rst(async low),clr,en,last_hw; out last_cycle,last_phase,hw
module sram_phase_counter
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] last_hw,
  output logic       last_cycle,
  output logic       last_phase,
  output logic [1:0] hw
);
  localparam int WW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  logic [WW-1:0] wcnt;
  assign last_cycle = wcnt == WW'(ACCESS_CYCLES - 1);
  assign last_phase = hw == last_hw;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wcnt <= '0;
      hw <= '0;
    end else if (clr) begin
      wcnt <= '0;
      hw <= '0;
    end else if (en) begin
      wcnt <= last_cycle ? '0 : wcnt + 1'b1;
      hw <= last_cycle ? hw + 1'b1 : hw;
    end
endmodule

// File: rtl/sram_ctrl_64b.sv
// sram_ctrl_64b: cache-side 64b block read / 32b word write over 16b SRAM; in clk,rst(async low),rd_en,wr_en,addr,wr_data; out rd_data,rdy,SRAM_*
module sram_ctrl_64b
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            addr,
  input  logic [31:0]            wr_data,
  output logic [63:0]            rd_data,
  output logic                   rdy,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);
  logic [1:0] state;
  logic [16:0] addr_q;
  logic [31:0] data_q;
  logic last_cycle, last_phase, rd_s, wr_s;
  logic [1:0] hw;
  logic unused_addr;
  assign unused_addr = ^{addr[31:19], addr[1:0]};
  assign rd_s = state == S_RD;
  assign wr_s = state == S_WR;
  sram_phase_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(!(rd_s || wr_s)),
    .en(rd_s || wr_s),
    .last_hw(rd_s ? 2'(RD_PHASES - 1) : 2'(WR_PHASES - 1)),
    .last_cycle(last_cycle),
    .last_phase(last_phase),
    .hw(hw)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else if (state == S_IDLE) begin
      if (wr_en || rd_en) begin
        state <= wr_en ? S_WR : S_RD;
        addr_q <= addr[18:2];
        data_q <= wr_data;
      end
    end else if ((rd_s || wr_s) && last_cycle && last_phase) begin
      state <= S_DONE;
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) rd_data <= '0;
    else if (rd_s && last_cycle) rd_data[{hw, 4'b0000} +: 16] <= SRAM_DQ;
  assign rdy = state == S_DONE;
  assign SRAM_CE_N = !(rd_s || wr_s);
  assign SRAM_OE_N = !rd_s;
  // the final cycle of each write phase lifts WE_N so data is held past the strobe edge
  assign SRAM_WE_N = !(wr_s && (!last_cycle || ACCESS_CYCLES == 1));
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_ADDR = rd_s ? SRAM_ADDR_W'({addr_q[16:1], hw}) : wr_s ? SRAM_ADDR_W'({addr_q, hw[0]}) : '0;
  assign SRAM_DQ = wr_s ? (hw[0] ? data_q[31:16] : data_q[15:0]) : 16'hzzzz;
endmodule

// File: tb/tb_sram_ctrl_64b.sv
// tb_sram_ctrl_64b: randomized bench with behavioural SRAM and reference model for sram_ctrl_64b
module tb_sram_ctrl_64b;
  localparam int AC = 2;
  localparam logic [15:0] PROBE = 16'hA5C3;
  logic clk = 0, rst = 1, rd_en = 0, wr_en = 0, rd1 = 0, rd3 = 0;
  logic [31:0] addr = 0, wr_data = 0;
  logic [63:0] rd_data, rd_data1, rd_data3;
  logic rdy, rdy1, rdy3;
  wire [15:0] dq, dq1, dq3;
  logic [17:0] sa, sa1, sa3;
  logic we_n, oe_n, ce_n, ub_n, lb_n, we1, oe1, ce1, ub1, lb1, we3, oe3, ce3, ub3, lb3;
  sram_ctrl_64b #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rdy(rdy), .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n));
  sram_ctrl_64b #(.ACCESS_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(1'b0), .addr(32'h800), .wr_data(32'h0),
    .rd_data(rd_data1), .rdy(rdy1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1),
    .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1));
  sram_ctrl_64b #(.ACCESS_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .rd_en(rd3), .wr_en(1'b0), .addr(32'h800), .wr_data(32'h0),
    .rd_data(rd_data3), .rdy(rdy3), .SRAM_DQ(dq3), .SRAM_ADDR(sa3), .SRAM_WE_N(we3),
    .SRAM_OE_N(oe3), .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3));
  always #5 clk = ~clk;
  logic [15:0] mem [0:262143];
  logic [15:0] ref_mem [0:262143];
  // deselected bus carries a probe pattern, so any stray controller drive shows up as a changed value
  assign dq = (!ce_n && !oe_n && we_n) ? mem[sa] : ce_n ? PROBE : 16'hzzzz;
  assign dq1 = (!ce1 && !oe1) ? (sa1[15:0] ^ 16'h5A5A) : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3) ? (sa3[15:0] ^ 16'h5A5A) : 16'hzzzz;
  always @(posedge we_n) if (rst && !ce_n) mem[sa] = dq;
  int compared = 0, mismatched = 0, cyc = 0;
  bit started = 0, is_rd = 0;
  int acc_k = -100, done_k = -100, next_ok = 0;
  logic [31:0] cur_a = 0, cur_d = 0;
  logic [63:0] exp_blk = 0, rd_hold = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", nm, a, e, cyc);
    end
  endtask
  function automatic logic [63:0] block(input logic [31:0] a);
    return {ref_mem[{a[18:3], 2'd3}], ref_mem[{a[18:3], 2'd2}], ref_mem[{a[18:3], 2'd1}], ref_mem[{a[18:3], 2'd0}]};
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_k = -100;
      done_k = -100;
      next_ok = cyc + 1;
      rd_hold = 0;
    end else begin
      cyc++;
      if (cyc == done_k) begin
        if (is_rd) rd_hold = exp_blk;
        else begin
          ref_mem[{cur_a[18:2], 1'b0}] = cur_d[15:0];
          ref_mem[{cur_a[18:2], 1'b1}] = cur_d[31:16];
        end
      end
      if (cyc >= next_ok && (rd_en || wr_en)) begin
        acc_k = cyc;
        is_rd = !wr_en;
        cur_a = addr;
        cur_d = wr_data;
        exp_blk = block(addr);
        done_k = cyc + (is_rd ? 4 : 2) * AC;
        next_ok = done_k + 2;
      end
    end
  end
  int c_pos;
  logic [1:0] c_ph;
  bit act;
  always @(negedge clk) if (started) begin
    if (!rst) begin
      chk("rst_rdy", rdy, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_ce_n", ce_n, 1);
      chk("rst_we_n", we_n, 1);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_dq_released", dq, PROBE);
    end else begin
      chk("rdy", rdy, cyc == done_k);
      act = cyc >= acc_k && cyc < done_k;
      c_ph = 2'((cyc - acc_k) / AC);
      c_pos = (cyc - acc_k) % AC;
      if (!act) begin
        chk("idle_ce_n", ce_n, 1);
        chk("idle_we_n", we_n, 1);
        chk("idle_oe_n", oe_n, 1);
        chk("idle_dq_released", dq, PROBE);
      end else if (is_rd) begin
        chk("rd_strobes", {ce_n, oe_n, we_n}, 3'b001);
        chk("rd_addr", sa, {cur_a[18:3], c_ph});
      end else begin
        chk("wr_ce_oe", {ce_n, oe_n}, 2'b01);
        chk("wr_we_n", we_n, c_pos == AC - 1 && AC > 1);
        chk("wr_addr", sa, {cur_a[18:2], c_ph[0]});
        chk("wr_dq", dq, c_ph[0] ? cur_d[31:16] : cur_d[15:0]);
      end
      if (!(act && is_rd)) chk("rd_data_hold", rd_data, rd_hold);
    end
  end
  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, output int lat);
    int c0;
    bit got;
    @(posedge clk);
    #1;
    rd_en = rd;
    wr_en = wr;
    addr = a;
    wr_data = d;
    c0 = cyc;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rdy) got = 1;
    end
    lat = cyc - (c0 + 1);
    if (!got) chk("req_timeout", 0, 1);
    @(posedge clk);
    #1;
    rd_en = 0;
    wr_en = 0;
  endtask
  task automatic alt_read(input int ac, output int lat, output logic [63:0] data);
    int c0;
    bit got;
    @(posedge clk);
    #1;
    if (ac == 1) rd1 = 1; else rd3 = 1;
    c0 = cyc;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ac == 1 ? rdy1 : rdy3) got = 1;
    end
    lat = cyc - (c0 + 1);
    data = ac == 1 ? rd_data1 : rd_data3;
    if (!got) chk("alt_timeout", 0, 1);
    @(posedge clk);
    #1;
    rd1 = 0;
    rd3 = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, n, r1, r2, k;
    logic [31:0] a;
    logic [63:0] d64;
    for (int i = 0; i < 262144; i++) begin
      mem[i] = 16'(i * 40503 + 7);
      ref_mem[i] = mem[i];
    end
    mem[18'h400] = 16'h1111; mem[18'h401] = 16'h2222; mem[18'h402] = 16'h3333; mem[18'h403] = 16'h4444;
    for (int i = 0; i < 4; i++) ref_mem[18'h400 + i] = mem[18'h400 + i];
    #3;
    rst = 0;
    started = 1;
    rd_en = 1;
    addr = 32'h800;
    repeat (4) @(negedge clk);
    chk("reset_hold_rdy", rdy, 0);
    chk("reset_hold_rd_data", rd_data, 0);
    rd_en = 0;
    rst = 1;
    req(1, 0, 32'h0000_0800, 0, lat);
    chk("rd_latency", lat, 8);
    chk("rd_block", rd_data, 64'h4444_3333_2222_1111);
    req(0, 1, 32'h0000_0804, 32'hDEAD_BEEF, lat);
    chk("wr_latency", lat, 4);
    chk("wr_mem_lo", mem[18'h402], 16'hBEEF);
    chk("wr_mem_hi", mem[18'h403], 16'hDEAD);
    req(1, 0, 32'h0000_0800, 0, lat);
    chk("readback_block", rd_data, 64'hDEAD_BEEF_2222_1111);
    req(1, 1, 32'h0000_0804, 32'hCAFE_F00D, lat);
    chk("both_latency", lat, 4);
    chk("both_rd_data_kept", rd_data, 64'hDEAD_BEEF_2222_1111);
    chk("both_mem_lo", mem[18'h402], 16'hF00D);
    @(posedge clk);
    #1;
    rd_en = 1;
    addr = 32'h800;
    n = 0;
    r1 = 0;
    r2 = 0;
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(negedge clk);
      if (rdy) begin
        if (n == 0) r1 = cyc; else r2 = cyc;
        n++;
      end
    end
    chk("b2b_count", n, 2);
    chk("b2b_gap_ge9", r2 - r1 >= 9, 1);
    @(posedge clk);
    #1;
    rd_en = 0;
    @(posedge clk);
    #1;
    wr_en = 1;
    addr = 32'h2000;
    wr_data = 32'h7777_8888;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_we_low_before", we_n, 0);
    rst = 0;
    #1;
    chk("abort_we_n", we_n, 1);
    chk("abort_dq_released", dq, PROBE);
    chk("abort_no_rdy", rdy, 0);
    wr_en = 0;
    // the first halfword was already committed by the WE_N rise that ended phase 0
    ref_mem[18'h1000] = 16'h8888;
    @(negedge clk);
    rst = 1;
    req(1, 0, 32'h0000_2000, 0, lat);
    chk("post_abort_latency", lat, 8);
    chk("post_abort_hw0", rd_data[15:0], 16'h8888);
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[18:6] = 13'($urandom_range(0, 3));
      req(k != 1, k == 1 || k == 2, a, $urandom, lat);
      chk("rand_latency", lat, (k == 1 || k == 2) ? 4 : 8);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    alt_read(1, lat, d64);
    chk("ac1_latency", lat, 4);
    chk("ac1_block", d64, 64'h5E59_5E58_5E5B_5E5A);
    alt_read(3, lat, d64);
    chk("ac3_latency", lat, 12);
    chk("ac3_block", d64, 64'h5E59_5E58_5E5B_5E5A);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
